// File: rtl/dual_num_count_date_pkg.sv
// dual_num_count_date_pkg: shared calendar constants, adjust-select codes and BCD helpers
package dual_num_count_date_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [7:0] MON_LEN_31 = 8'h31;
  localparam logic [7:0] MON_LEN_30 = 8'h30;
  localparam logic [7:0] MON_LEN_FEB = 8'h28;
  localparam logic [7:0] MON_LEN_FEB_LEAP = 8'h29;
  localparam logic [1:0] SEL_DAY = 2'b00;
  localparam logic [1:0] SEL_MON = 2'b01;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  function automatic logic [7:0] bin2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/dual_num_count_date_if.sv
// dual_num_count_date_if: adjust/trigger/year inputs and BCD date outputs of the date stage
interface dual_num_count_date_if;
  import dual_num_count_date_pkg::*;
  logic I_ADJ_UP;
  logic I_ADJ_DOWN;
  logic [1:0] I_ADJ_SEL;
  logic I_TRIG_F;
  bcd_t I_YEARA;
  bcd_t I_YEARB;
  logic O_TRIG_F;
  bcd_t O_DAYA;
  bcd_t O_DAYB;
  bcd_t O_MONA;
  bcd_t O_MONB;
  modport master (output I_ADJ_UP, I_ADJ_DOWN, I_ADJ_SEL, I_TRIG_F, I_YEARA, I_YEARB,
                  input O_TRIG_F, O_DAYA, O_DAYB, O_MONA, O_MONB);
  modport slave (input I_ADJ_UP, I_ADJ_DOWN, I_ADJ_SEL, I_TRIG_F, I_YEARA, I_YEARB,
                 output O_TRIG_F, O_DAYA, O_DAYB, O_MONA, O_MONB);
endinterface

// File: rtl/dual_num_count_date_days_in_month.sv
// date_days_in_month: BCD month length; Feb leap handling enabled by DUAL_NUM_COUNT_DATE_LEAP_EN
module date_days_in_month
  import dual_num_count_date_pkg::*;
(
  input  bcd_t mon_b,
  input  bcd_t mon_a,
  input  bcd_t year_b,
  input  bcd_t year_a,
  output bcd_t max_b,
  output bcd_t max_a
);
  logic leap;
  logic [7:0] mon;
`ifdef DUAL_NUM_COUNT_DATE_LEAP_EN
  // divisible by 4 in BCD: even tens with units 0/4/8, odd tens with units 2/6
  assign leap = year_b <= 4'd9 && (year_b[0] ? (year_a == 4'd2 || year_a == 4'd6)
                                             : (year_a == 4'd0 || year_a == 4'd4 || year_a == 4'd8));
`else
  logic unused_year;
  assign leap = 1'b0;
  assign unused_year = ^{year_b, year_a};
`endif
  assign mon = {mon_b, mon_a};
  assign {max_b, max_a} = mon == 8'h02 ? (leap ? MON_LEN_FEB_LEAP : MON_LEN_FEB) :
                          (mon == 8'h04 || mon == 8'h06 || mon == 8'h09 || mon == 8'h11) ? MON_LEN_30 : MON_LEN_31;
endmodule

// File: rtl/dual_num_count_date.sv
// dual_num_count_date: BCD day/month counter with day-carry input, year-carry pulse and manual adjust
module dual_num_count_date
  import dual_num_count_date_pkg::*;
#(
  parameter int PAR_DAY_RST = 1,
  parameter int PAR_MON_RST = 1
) (
  input logic I_SYS_CLK,
  input logic I_EXT_RST,
  dual_num_count_date_if.slave bus
);
  logic [7:0] day, mon, cur_max, tgt_max, mon_up, mon_dn, mon_tgt, day_up, day_dn;
  logic trig_q, adj, at_end;
  assign adj = bus.I_ADJ_UP | bus.I_ADJ_DOWN;
  assign at_end = day >= cur_max;
  assign mon_up = mon == 8'h12 ? 8'h01 : bcd_inc(mon);
  assign mon_dn = mon == 8'h01 ? 8'h12 : bcd_dec(mon);
  assign mon_tgt = bus.I_ADJ_UP ? mon_up : mon_dn;
  assign day_up = at_end ? 8'h01 : bcd_inc(day);
  assign day_dn = (day == 8'h01 || day > cur_max) ? cur_max : bcd_dec(day);
  date_days_in_month u_cur (
    .mon_b(mon[7:4]), .mon_a(mon[3:0]), .year_b(bus.I_YEARB), .year_a(bus.I_YEARA),
    .max_b(cur_max[7:4]), .max_a(cur_max[3:0])
  );
  // length of the month an adjust would move to, for clamping the day
  date_days_in_month u_tgt (
    .mon_b(mon_tgt[7:4]), .mon_a(mon_tgt[3:0]), .year_b(bus.I_YEARB), .year_a(bus.I_YEARA),
    .max_b(tgt_max[7:4]), .max_a(tgt_max[3:0])
  );
  always_ff @(posedge I_SYS_CLK or posedge I_EXT_RST) begin
    if (I_EXT_RST) begin
      day <= bin2bcd(PAR_DAY_RST);
      mon <= bin2bcd(PAR_MON_RST);
      trig_q <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (adj) begin
        if (bus.I_ADJ_SEL == SEL_DAY) day <= bus.I_ADJ_UP ? day_up : day_dn;
        else if (bus.I_ADJ_SEL == SEL_MON) begin
          mon <= mon_tgt;
          if (day > tgt_max) day <= tgt_max;
        end
      end else if (bus.I_TRIG_F) begin
        day <= day_up;
        if (at_end) mon <= mon_up;
        trig_q <= at_end && mon == 8'h12;
      end
    end
  end
  assign bus.O_TRIG_F = trig_q;
  assign {bus.O_DAYB, bus.O_DAYA} = day;
  assign {bus.O_MONB, bus.O_MONA} = mon;
endmodule

// File: tb/tb_dual_num_count_date.sv
// tb_dual_num_count_date: scoreboard bench for the BCD date stage
module tb_dual_num_count_date;
  logic I_SYS_CLK = 1'b0;
  logic I_EXT_RST = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];
  typedef struct {
    int sm;
    int sd;
    logic up;
    logic dn;
    logic [1:0] sel;
    logic trg;
    logic [16:0] exp;
  } step_t;

  dual_num_count_date_if bus ();
  dual_num_count_date dut (.I_SYS_CLK(I_SYS_CLK), .I_EXT_RST(I_EXT_RST), .bus(bus));

  always #5 I_SYS_CLK = ~I_SYS_CLK;

  function automatic logic [16:0] observed();
    return {bus.O_TRIG_F, bus.O_MONB, bus.O_MONA, bus.O_DAYB, bus.O_DAYA};
  endfunction

  function automatic step_t st(int sm, int sd, logic up, logic dn, logic [1:0] sel, logic trg, logic [16:0] exp);
    step_t s;
    s.sm = sm; s.sd = sd; s.up = up; s.dn = dn; s.sel = sel; s.trg = trg; s.exp = exp;
    return s;
  endfunction

  task automatic tick(input logic up, input logic dn, input logic [1:0] sel, input logic trg);
    bus.I_ADJ_UP = up;
    bus.I_ADJ_DOWN = dn;
    bus.I_ADJ_SEL = sel;
    bus.I_TRIG_F = trg;
    @(posedge I_SYS_CLK);
    #1;
    bus.I_ADJ_UP = 1'b0;
    bus.I_ADJ_DOWN = 1'b0;
    bus.I_ADJ_SEL = 2'b00;
    bus.I_TRIG_F = 1'b0;
  endtask

  // reset to 01/01, then walk month and day up with the adjust controls
  task automatic set_date(input int m, input int d);
    I_EXT_RST = 1'b1;
    #1;
    I_EXT_RST = 1'b0;
    repeat (m - 1) tick(1'b1, 1'b0, 2'b01, 1'b0);
    repeat (d - 1) tick(1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    logic [16:0] e, got;
    set_date(7, 15);
    exp_q.push_back({1'b0, 8'h07, 8'h15});
    got = observed(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_setup: got %h expected %h", got, e); end
    bus.I_TRIG_F = 1'b1;
    bus.I_ADJ_UP = 1'b1;
    #3;
    I_EXT_RST = 1'b1;
    exp_q.push_back({1'b0, 8'h01, 8'h01});
    #1;
    got = observed(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_async: got %h expected %h", got, e); end
    @(negedge I_SYS_CLK);
    I_EXT_RST = 1'b0;
    exp_q.push_back({1'b0, 8'h01, 8'h01});
    tick(1'b0, 1'b0, 2'b00, 1'b0);
    got = observed(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", got, e); end
  endtask

  task automatic test_month_end();
    step_t s[$];
    logic [16:0] e, got;
    bus.I_YEARB = 4'd2; bus.I_YEARA = 4'd3;
    s.push_back(st(1, 31, 0, 0, 2'b00, 1, {1'b0, 8'h02, 8'h01}));
    s.push_back(st(4, 30, 0, 0, 2'b00, 1, {1'b0, 8'h05, 8'h01}));
    s.push_back(st(1, 9, 0, 0, 2'b00, 1, {1'b0, 8'h01, 8'h10}));
    s.push_back(st(0, 0, 0, 0, 2'b00, 0, {1'b0, 8'h01, 8'h10}));
    s.push_back(st(6, 29, 0, 0, 2'b00, 1, {1'b0, 8'h06, 8'h30}));
    s.push_back(st(0, 0, 0, 0, 2'b00, 1, {1'b0, 8'h07, 8'h01}));
    foreach (s[i]) begin
      if (s[i].sm != 0) set_date(s[i].sm, s[i].sd);
      exp_q.push_back(s[i].exp);
      tick(s[i].up, s[i].dn, s[i].sel, s[i].trg);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL month_end step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_year();
    step_t s[$];
    logic [16:0] e, got;
    s.push_back(st(12, 30, 0, 0, 2'b00, 1, {1'b0, 8'h12, 8'h31}));
    s.push_back(st(0, 0, 0, 0, 2'b00, 1, {1'b1, 8'h01, 8'h01}));
    s.push_back(st(0, 0, 0, 0, 2'b00, 0, {1'b0, 8'h01, 8'h01}));
    s.push_back(st(0, 0, 0, 0, 2'b00, 1, {1'b0, 8'h01, 8'h02}));
    foreach (s[i]) begin
      if (s[i].sm != 0) set_date(s[i].sm, s[i].sd);
      exp_q.push_back(s[i].exp);
      tick(s[i].up, s[i].dn, s[i].sel, s[i].trg);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL year step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_leap();
    step_t s[$];
    logic [16:0] e, got;
    bus.I_YEARB = 4'd2; bus.I_YEARA = 4'd4;
`ifdef DUAL_NUM_COUNT_DATE_LEAP_EN
    s.push_back(st(2, 28, 0, 0, 2'b00, 1, {1'b0, 8'h02, 8'h29}));
    s.push_back(st(0, 0, 0, 0, 2'b00, 1, {1'b0, 8'h03, 8'h01}));
`else
    s.push_back(st(2, 28, 0, 0, 2'b00, 1, {1'b0, 8'h03, 8'h01}));
`endif
    foreach (s[i]) begin
      if (s[i].sm != 0) set_date(s[i].sm, s[i].sd);
      exp_q.push_back(s[i].exp);
      tick(s[i].up, s[i].dn, s[i].sel, s[i].trg);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL leap24 step %0d: got %h expected %h", i, got, e); end
    end
    s.delete();
    bus.I_YEARA = 4'd3;
    s.push_back(st(2, 28, 0, 0, 2'b00, 1, {1'b0, 8'h03, 8'h01}));
    s.push_back(st(2, 1, 0, 1, 2'b00, 0, {1'b0, 8'h02, 8'h28}));
    foreach (s[i]) begin
      if (s[i].sm != 0) set_date(s[i].sm, s[i].sd);
      exp_q.push_back(s[i].exp);
      tick(s[i].up, s[i].dn, s[i].sel, s[i].trg);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL leap23 step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_adjust();
    step_t s[$];
    logic [16:0] e, got;
    bus.I_YEARB = 4'd2; bus.I_YEARA = 4'd3;
    s.push_back(st(1, 31, 1, 0, 2'b01, 0, {1'b0, 8'h02, 8'h28}));
    s.push_back(st(4, 1, 0, 1, 2'b00, 0, {1'b0, 8'h04, 8'h30}));
    s.push_back(st(0, 0, 1, 0, 2'b00, 0, {1'b0, 8'h04, 8'h01}));
    s.push_back(st(0, 0, 1, 0, 2'b00, 0, {1'b0, 8'h04, 8'h02}));
    s.push_back(st(12, 15, 1, 0, 2'b01, 0, {1'b0, 8'h01, 8'h15}));
    s.push_back(st(0, 0, 1, 0, 2'b10, 0, {1'b0, 8'h01, 8'h15}));
    s.push_back(st(0, 0, 0, 1, 2'b01, 0, {1'b0, 8'h12, 8'h15}));
    s.push_back(st(0, 0, 0, 1, 2'b00, 0, {1'b0, 8'h12, 8'h14}));
    s.push_back(st(0, 0, 0, 1, 2'b01, 0, {1'b0, 8'h11, 8'h14}));
    s.push_back(st(3, 20, 0, 1, 2'b00, 0, {1'b0, 8'h03, 8'h19}));
    foreach (s[i]) begin
      if (s[i].sm != 0) set_date(s[i].sm, s[i].sd);
      exp_q.push_back(s[i].exp);
      tick(s[i].up, s[i].dn, s[i].sel, s[i].trg);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL adjust step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_priority();
    step_t s[$];
    logic [16:0] e, got;
    s.push_back(st(12, 31, 1, 0, 2'b00, 1, {1'b0, 8'h12, 8'h01}));
    s.push_back(st(0, 0, 0, 0, 2'b00, 0, {1'b0, 8'h12, 8'h01}));
    s.push_back(st(0, 0, 0, 1, 2'b00, 1, {1'b0, 8'h12, 8'h31}));
    s.push_back(st(0, 0, 1, 1, 2'b00, 0, {1'b0, 8'h12, 8'h01}));
    s.push_back(st(0, 0, 1, 0, 2'b11, 1, {1'b0, 8'h12, 8'h01}));
    foreach (s[i]) begin
      if (s[i].sm != 0) set_date(s[i].sm, s[i].sd);
      exp_q.push_back(s[i].exp);
      tick(s[i].up, s[i].dn, s[i].sel, s[i].trg);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL priority step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e, got;
    bus.I_YEARB = 4'd2; bus.I_YEARA = 4'd3;
    set_date(2, 27);
    exp_q.push_back({1'b0, 8'h02, 8'h28});
    exp_q.push_back({1'b0, 8'h03, 8'h01});
    exp_q.push_back({1'b0, 8'h03, 8'h02});
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 2'b00, 1'b1);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL back_to_back step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  initial begin
    bus.I_ADJ_UP = 1'b0;
    bus.I_ADJ_DOWN = 1'b0;
    bus.I_ADJ_SEL = 2'b00;
    bus.I_TRIG_F = 1'b0;
    bus.I_YEARA = 4'd3;
    bus.I_YEARB = 4'd2;
    I_EXT_RST = 1'b1;
    repeat (2) @(posedge I_SYS_CLK);
    #1;
    I_EXT_RST = 1'b0;
    test_reset();
    test_month_end();
    test_year();
    test_leap();
    test_adjust();
    test_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
